ring_burst_scheduler: RTL and testbench

RING_BURST_SCHEDULER -- requirements
Module: ring_burst_scheduler

---
 rtl/ring_burst_scheduler_pkg.sv | 12 +
 rtl/ring_burst_scheduler_if.sv | 23 ++
 rtl/ring_burst_scheduler_ring_ptr_counter.sv | 30 +++
 rtl/ring_burst_scheduler.sv | 131 +++++++++++++
 tb/tb_ring_burst_scheduler.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_burst_scheduler_pkg.sv
// Shared types and defaults for the ring burst scheduler.
package ring_burst_scheduler_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_WR = 2'd1,
    GRANT_RD = 2'd2
  } state_t;

endpackage

// File: rtl/ring_burst_scheduler_if.sv
// Writer/reader burst handshake: request, grant and completion for each side.
interface ring_burst_scheduler_if;

  logic wr_req;
  logic wr_done;
  logic wr_grant;
  logic rd_req;
  logic rd_done;
  logic rd_grant;

  // Client side: raises requests and completions, receives grants.
  modport master (
    output wr_req, wr_done, rd_req, rd_done,
    input  wr_grant, rd_grant
  );

  // Scheduler side: samples requests and completions, issues grants.
  modport slave (
    input  wr_req, wr_done, rd_req, rd_done,
    output wr_grant, rd_grant
  );

endinterface

// File: rtl/ring_burst_scheduler_ring_ptr_counter.sv
// Burst slot pointer that wraps to zero after slot ring_size-1.
module ring_ptr_counter
  import ring_burst_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  increment,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] ring_size,
  output logic [ADDR_WIDTH-1:0] ptr
);

  logic [ADDR_WIDTH-1:0] last_slot;

  assign last_slot = ring_size - ADDR_WIDTH'(1);

  // Advance one slot per completed burst; also wraps a pointer left beyond a shrunk ring.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (increment) begin
      ptr <= (ptr >= last_slot) ? '0 : ptr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ring_burst_scheduler.sv
// Round-robin burst scheduler between a ring writer and a ring reader.
module ring_burst_scheduler
  import ring_burst_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] ring_size,
  ring_burst_scheduler_if.slave hs,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  full,
  output logic                  empty,
  output logic                  done_err
);

  localparam int unsigned OCC_W = ADDR_WIDTH + 1;

  state_t           state;
  state_t           state_next;
  logic             last_wr;
  logic             last_wr_next;
  logic             wr_elig;
  logic             rd_elig;
  logic             wr_adv;
  logic             rd_adv;
  logic             err_set;
  logic             do_clear;
  logic [OCC_W-1:0] size_ext;

  assign size_ext = {1'b0, ring_size};
  assign full     = (occupancy == size_ext);
  assign empty    = (occupancy == '0);

  // Eligibility: writer needs a free slot, reader needs a filled one.
  always_comb begin
    wr_elig = hs.wr_req && (occupancy < size_ext);
    rd_elig = hs.rd_req && (occupancy != '0);
  end

  // Next-state, round-robin choice and completion bookkeeping.
  always_comb begin
    state_next   = state;
    last_wr_next = last_wr;
    wr_adv       = 1'b0;
    rd_adv       = 1'b0;
    do_clear     = 1'b0;
    err_set      = (hs.wr_done && (state != GRANT_WR)) ||
                   (hs.rd_done && (state != GRANT_RD));
    case (state)
      IDLE: begin
        if (clear) begin
          do_clear = 1'b1;
        end else if (enable) begin
          if (wr_elig && (!rd_elig || !last_wr)) begin
            state_next   = GRANT_WR;
            last_wr_next = 1'b1;
          end else if (rd_elig) begin
            state_next   = GRANT_RD;
            last_wr_next = 1'b0;
          end
        end
      end
      GRANT_WR: begin
        if (hs.wr_done) begin
          wr_adv     = (occupancy < size_ext);
          state_next = IDLE;
        end
      end
      GRANT_RD: begin
        if (hs.rd_done) begin
          rd_adv     = (occupancy != '0);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, registered grants, occupancy and sticky completion error.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      last_wr     <= 1'b0;
      hs.wr_grant <= 1'b0;
      hs.rd_grant <= 1'b0;
      occupancy   <= '0;
      done_err    <= 1'b0;
    end else begin
      state       <= state_next;
      last_wr     <= last_wr_next;
      hs.wr_grant <= (state_next == GRANT_WR);
      hs.rd_grant <= (state_next == GRANT_RD);
      if (do_clear) begin
        occupancy <= '0;
      end else if (wr_adv) begin
        occupancy <= occupancy + OCC_W'(1);
      end else if (rd_adv) begin
        occupancy <= occupancy - OCC_W'(1);
      end
      if (do_clear) begin
        done_err <= 1'b0;
      end else if (err_set) begin
        done_err <= 1'b1;
      end
    end
  end

  ring_ptr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .aclk      (aclk),
    .areset    (areset),
    .increment (wr_adv),
    .clear     (do_clear),
    .ring_size (ring_size),
    .ptr       (wr_ptr)
  );

  ring_ptr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .aclk      (aclk),
    .areset    (areset),
    .increment (rd_adv),
    .clear     (do_clear),
    .ring_size (ring_size),
    .ptr       (rd_ptr)
  );

endmodule

// File: tb/tb_ring_burst_scheduler.sv
// Self-checking bench for ring_burst_scheduler.
module tb_ring_burst_scheduler;

  localparam int unsigned AW = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          enable;
  logic          clear;
  logic [AW-1:0] ring_size;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occupancy;
  logic          full;
  logic          empty;
  logic          done_err;

  ring_burst_scheduler_if hs();

  ring_burst_scheduler #(.ADDR_WIDTH(AW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .enable    (enable),
    .clear     (clear),
    .ring_size (ring_size),
    .hs        (hs),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .done_err  (done_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          is_wr;
    int unsigned wr_ptr;
    int unsigned rd_ptr;
    int unsigned occ;
    bit          full;
    bit          empty;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[6];
  vec_t exp_q[$];
  bit   exp_grant_q[$];

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_grant"},  32'(hs.wr_grant), 0);
    check({tag, "_rd_grant"},  32'(hs.rd_grant), 0);
    check({tag, "_wr_ptr"},    32'(wr_ptr), 0);
    check({tag, "_rd_ptr"},    32'(rd_ptr), 0);
    check({tag, "_occupancy"}, 32'(occupancy), 0);
    check({tag, "_empty"},     32'(empty), 1);
    check({tag, "_full"},      32'(full), 0);
    check({tag, "_done_err"},  32'(done_err), 0);
  endtask

  task automatic wait_grant(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((is_wr ? hs.wr_grant : hs.rd_grant) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(is_wr ? "wr_grant_seen" : "rd_grant_seen", 32'(ok), 1);
  endtask

  // One complete burst: request, wait for grant, pulse done for a cycle.
  task automatic burst(input bit is_wr);
    bit ok;
    if (is_wr) hs.wr_req = 1'b1; else hs.rd_req = 1'b1;
    wait_grant(is_wr, ok);
    hs.wr_req = 1'b0;
    hs.rd_req = 1'b0;
    if (!ok) return;
    check("other_grant_low", 32'(is_wr ? hs.rd_grant : hs.wr_grant), 0);
    if (is_wr) hs.wr_done = 1'b1; else hs.rd_done = 1'b1;
    step();
    hs.wr_done = 1'b0;
    hs.rd_done = 1'b0;
  endtask

  task automatic no_grant_for(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      if (hs.wr_grant !== 1'b0 || hs.rd_grant !== 1'b0) seen++;
      step();
    end
    check(name, 32'(seen), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t e;
    bit   ok;
    bit   got;
    int   idle;

    areset     = 1'b1;
    enable     = 1'b0;
    clear      = 1'b0;
    ring_size  = AW'(4);
    hs.wr_req  = 1'b0;
    hs.wr_done = 1'b0;
    hs.rd_req  = 1'b0;
    hs.rd_done = 1'b0;

    #12;
    check_reset_outputs("reset");
    step();
    areset = 1'b0;
    enable = 1'b1;
    step();

    // Ring of 4: fill it, confirm the wrap and full, then drain two.
    vecs[0] = '{1'b1, 1, 0, 1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2, 0, 2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 3, 0, 3, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 0, 0, 4, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 0, 1, 3, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 0, 2, 2, 1'b0, 1'b0};

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i]);
      burst(vecs[i].is_wr);
      e = exp_q.pop_front();
      check("tbl_wr_ptr",    32'(wr_ptr),    e.wr_ptr);
      check("tbl_rd_ptr",    32'(rd_ptr),    e.rd_ptr);
      check("tbl_occupancy", 32'(occupancy), e.occ);
      check("tbl_full",      32'(full),      32'(e.full));
      check("tbl_empty",     32'(empty),     32'(e.empty));
      if (e.full) begin
        hs.wr_req = 1'b1;
        no_grant_for("no_wr_grant_when_full", 8);
        hs.wr_req = 1'b0;
      end
    end

    // Both sides eligible at occupancy 2: strict alternation, one idle cycle apart.
    exp_grant_q.push_back(1'b1);
    exp_grant_q.push_back(1'b0);
    exp_grant_q.push_back(1'b1);
    exp_grant_q.push_back(1'b0);
    hs.wr_req = 1'b1;
    hs.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 20; k++) begin
        if (hs.wr_grant === 1'b1 || hs.rd_grant === 1'b1) break;
        step();
      end
      got = hs.wr_grant;
      check("alt_grant_side", 32'(got), 32'(exp_grant_q.pop_front()));
      check("alt_one_hot", 32'(hs.wr_grant & hs.rd_grant), 0);
      if (i == 3) begin
        hs.wr_req = 1'b0;
        hs.rd_req = 1'b0;
      end
      if (got) hs.wr_done = 1'b1; else hs.rd_done = 1'b1;
      step();
      hs.wr_done = 1'b0;
      hs.rd_done = 1'b0;
      if (i < 3) begin
        idle = 0;
        while (hs.wr_grant !== 1'b1 && hs.rd_grant !== 1'b1 && idle < 20) begin
          idle++;
          step();
        end
        check("alt_idle_gap", 32'(idle), 1);
      end
    end
    step();
    check("alt_wr_ptr",    32'(wr_ptr),    2);
    check("alt_rd_ptr",    32'(rd_ptr),    0);
    check("alt_occupancy", 32'(occupancy), 2);
    check("alt_done_err",  32'(done_err),  0);

    // Stray rd_done in IDLE flags an error without touching the ring; clear resets.
    hs.rd_done = 1'b1;
    step();
    hs.rd_done = 1'b0;
    check("stray_done_err",  32'(done_err),  1);
    check("stray_occupancy", 32'(occupancy), 2);
    check("stray_rd_ptr",    32'(rd_ptr),    0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_done_err",  32'(done_err),  0);
    check("clear_wr_ptr",    32'(wr_ptr),    0);
    check("clear_rd_ptr",    32'(rd_ptr),    0);
    check("clear_occupancy", 32'(occupancy), 0);
    check("clear_empty",     32'(empty),     1);

    // Empty ring: reader starves until one write lands, then is granted 2 cycles later.
    hs.rd_req = 1'b1;
    no_grant_for("rd_no_grant_empty", 8);
    hs.wr_req = 1'b1;
    wait_grant(1'b1, ok);
    hs.wr_req  = 1'b0;
    hs.wr_done = 1'b1;
    step();
    hs.wr_done = 1'b0;
    check("rd_grant_1_after_done", 32'(hs.rd_grant), 0);
    step();
    check("rd_grant_2_after_done", 32'(hs.rd_grant), 1);
    hs.rd_req  = 1'b0;
    hs.rd_done = 1'b1;
    step();
    hs.rd_done = 1'b0;
    check("rd_after_wr_occupancy", 32'(occupancy), 0);
    check("rd_after_wr_rd_ptr",    32'(rd_ptr),    1);
    check("rd_after_wr_wr_ptr",    32'(wr_ptr),    1);

    // Enable drops mid write burst: burst completes, then nothing new is granted.
    hs.wr_req = 1'b1;
    wait_grant(1'b1, ok);
    enable = 1'b0;
    step();
    step();
    check("wr_grant_held_disabled", 32'(hs.wr_grant), 1);
    hs.wr_done = 1'b1;
    step();
    hs.wr_done = 1'b0;
    check("disabled_wr_ptr",    32'(wr_ptr),    2);
    check("disabled_occupancy", 32'(occupancy), 1);
    hs.rd_req = 1'b1;
    no_grant_for("disabled_no_grant", 6);
    hs.wr_req = 1'b0;

    // Reset mid read burst abandons it; a late rd_done is then an error.
    enable = 1'b1;
    wait_grant(1'b0, ok);
    hs.rd_req = 1'b0;
    areset    = 1'b1;
    #1;
    check_reset_outputs("reset_mid_rd");
    step();
    step();
    areset = 1'b0;
    step();
    hs.rd_done = 1'b1;
    step();
    hs.rd_done = 1'b0;
    check("late_done_err",       32'(done_err),  1);
    check("late_done_occupancy", 32'(occupancy), 0);
    check("late_done_rd_ptr",    32'(rd_ptr),    0);

    // Single-slot ring: pointer stays at 0 and one write fills it.
    ring_size = AW'(1);
    step();
    burst(1'b1);
    check("size1_wr_ptr",    32'(wr_ptr),    0);
    check("size1_occupancy", 32'(occupancy), 1);
    check("size1_full",      32'(full),      1);
    check("size1_empty",     32'(empty),     0);
    hs.wr_req = 1'b1;
    no_grant_for("size1_no_grant_full", 6);
    hs.wr_req = 1'b0;
    burst(1'b0);
    check("size1_rd_ptr",     32'(rd_ptr),    0);
    check("size1_drained",    32'(occupancy), 0);
    check("size1_empty_again", 32'(empty),    1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
